// File: rtl/tick_generator.sv
// tick_generator: multi-channel programmable tick source.
// Each channel runs an up-counter that wraps at its own period.
module tick_generator #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned WIDTH          = 31,
  parameter int unsigned DEFAULT_PERIOD = 250_000,
  parameter bit          AUTOSTART      = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS-1:0]       oneshot,
  input  logic [CHANNELS*WIDTH-1:0] period_in,
  output logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS-1:0]       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] DEF_PER = WIDTH'(DEFAULT_PERIOD);
  localparam state_t RST_STATE = AUTOSTART ? RUN : IDLE;

  state_t           state_q  [CHANNELS];
  state_t           state_d  [CHANNELS];
  logic [WIDTH-1:0] count_q  [CHANNELS];
  logic [WIDTH-1:0] count_d  [CHANNELS];
  logic [WIDTH-1:0] period_q [CHANNELS];
  logic [WIDTH-1:0] period_d [CHANNELS];
  logic [CHANNELS-1:0] pulse_q;
  logic [CHANNELS-1:0] pulse_d;

  logic [CHANNELS-1:0] sel_stop;
  logic [CHANNELS-1:0] sel_strobe;
  logic [CHANNELS-1:0] sel_hold;
  logic [CHANNELS-1:0] sel_run;

  // One-hot per-channel action: stop > load/start > hold > count
  assign sel_stop   = stop;
  assign sel_strobe = ~stop & (load | start);
  assign sel_hold   = ~stop & ~load & ~start & {CHANNELS{hold}};
  assign sel_run    = ~stop & ~load & ~start & ~{CHANNELS{hold}} & busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= RST_STATE;
        count_q[i]  <= '0;
        period_q[i] <= DEF_PER;
      end
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        period_q[i] <= period_d[i];
      end
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      period_d[i] = period_q[i];
      pulse_d[i]  = 1'b0;
      unique case (1'b1)
        sel_stop[i]: begin
          state_d[i] = IDLE;
          count_d[i] = '0;
        end
        sel_strobe[i]: begin
          if (load[i])
            period_d[i] = period_in[i*WIDTH +: WIDTH];
          if (start[i])
            state_d[i] = RUN;
          count_d[i] = '0;
        end
        sel_hold[i]: begin
        end
        sel_run[i]: begin
          if (count_q[i] == period_q[i]) begin
            count_d[i] = '0;
            pulse_d[i] = 1'b1;
            if (oneshot[i])
              state_d[i] = IDLE;
          end else begin
            count_d[i] = count_q[i] + 1'b1;
          end
        end
        default: count_d[i] = '0;
      endcase
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < CHANNELS; i++)
      busy[i] = (state_q[i] == RUN);
  end

  assign pulse = pulse_q;

endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: vector table, directed corner sequences and
// randomized traffic checked against a countdown reference model.
module tb_tick_generator;

  localparam int CH  = 4;
  localparam int W   = 8;
  localparam int DEF = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            hold;
  logic [CH-1:0]   start;
  logic [CH-1:0]   stop;
  logic [CH-1:0]   load;
  logic [CH-1:0]   oneshot;
  logic [CH*W-1:0] period_in;
  logic [CH-1:0]   pulse;
  logic [CH-1:0]   busy;

  int tests = 0;
  int fails = 0;

  // Model: cycles remaining until the next tick, per channel
  int            m_per [CH];
  int            m_rem [CH];
  bit            m_run [CH];
  logic [CH-1:0] m_pulse = '0;
  logic [CH-1:0] os_cfg  = '0;

  tick_generator #(
    .CHANNELS(CH),
    .WIDTH(W),
    .DEFAULT_PERIOD(DEF),
    .AUTOSTART(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hold(hold),
    .start(start),
    .stop(stop),
    .load(load),
    .oneshot(oneshot),
    .period_in(period_in),
    .pulse(pulse),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [CH*W-1:0] sl(input int ch, input int v);
    sl = '0;
    sl[ch*W +: W] = W'(v);
  endfunction

  task automatic step(input logic r, input logic h,
                      input logic [CH-1:0] st, input logic [CH-1:0] sp,
                      input logic [CH-1:0] ld, input logic [CH*W-1:0] pin);
    logic [CH-1:0] mb;
    reset = r; hold = h; start = st; stop = sp; load = ld;
    oneshot = os_cfg; period_in = pin;
    for (int i = 0; i < CH; i++) begin
      m_pulse[i] = 1'b0;
      if (r) begin
        m_per[i] = DEF; m_rem[i] = DEF + 1; m_run[i] = 1'b1;
      end else if (sp[i]) begin
        m_run[i] = 1'b0;
      end else if (ld[i] || st[i]) begin
        if (ld[i]) m_per[i] = int'(pin[i*W +: W]);
        m_rem[i] = m_per[i] + 1;
        if (st[i]) m_run[i] = 1'b1;
      end else if (!h && m_run[i]) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_pulse[i] = 1'b1;
          m_rem[i] = m_per[i] + 1;
          if (os_cfg[i]) m_run[i] = 1'b0;
        end
      end
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < CH; i++) mb[i] = m_run[i];
    check("model_pulse", 32'(pulse), 32'(m_pulse));
    check("model_busy", 32'(busy), 32'(mb));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  typedef struct {
    logic rst, hld, st, sp, ld, os;
    int   per;
    logic ep, eb;
  } vec_t;

  function automatic vec_t mk(input logic r, h, st, sp, ld, os,
                              input int per, input logic ep, eb);
    mk.rst = r; mk.hld = h; mk.st = st; mk.sp = sp;
    mk.ld = ld; mk.os = os; mk.per = per; mk.ep = ep; mk.eb = eb;
  endfunction

  vec_t tbl [17];
  int   q [$];
  int   n, first;
  logic hh;
  logic [CH-1:0] rs, rp, rl;
  logic [CH*W-1:0] rpin;

  initial begin
    reset = 1'b1; hold = 1'b0; start = '0; stop = '0;
    load = '0; oneshot = '0; period_in = '0;

    // Channel 0 only: r h st sp ld os per | pulse busy
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[6]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 1, 0, 1, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 17; k++) begin
      os_cfg = {3'b000, tbl[k].os};
      step(tbl[k].rst, tbl[k].hld, {3'b000, tbl[k].st},
           {3'b000, tbl[k].sp}, {3'b000, tbl[k].ld}, sl(0, tbl[k].per));
      check($sformatf("vec%0d_pulse", k), 32'(pulse[0]), 32'(tbl[k].ep));
      check($sformatf("vec%0d_busy", k), 32'(busy[0]), 32'(tbl[k].eb));
    end
    os_cfg = '0;

    // Default period after reset: ticks 5, 10, 15
    step(1'b1, 1'b0, '0, '0, '0, '0);
    check("reset_pulse", 32'(pulse), 0);
    check("reset_busy", 32'(busy), 32'hF);
    q.delete();
    for (int k = 1; k <= 15; k++) begin
      idle();
      if (pulse[0]) q.push_back(k);
    end
    check("t1_count", q.size(), 3);
    if (q.size() == 3) begin
      check("t1_p0", q[0], 5);
      check("t1_p1", q[1], 10);
      check("t1_p2", q[2], 15);
    end

    // load+start with period 2: every 3 cycles
    step(1'b0, 1'b0, 4'b0010, '0, 4'b0010, sl(1, 2));
    check("t2_busy", 32'(busy[1]), 1);
    q.delete();
    for (int k = 1; k <= 9; k++) begin
      idle();
      if (pulse[1]) q.push_back(k);
    end
    check("t2_count", q.size(), 3);
    if (q.size() == 3) begin
      check("t2_p0", q[0], 3);
      check("t2_p1", q[1], 6);
      check("t2_p2", q[2], 9);
    end

    // One-shot, period 3
    os_cfg = 4'b0100;
    step(1'b0, 1'b0, 4'b0100, '0, 4'b0100, sl(2, 3));
    n = 0;
    for (int k = 1; k <= 24; k++) begin
      idle();
      if (k == 4) begin
        check("t3_pulse", 32'(pulse[2]), 1);
        check("t3_busy", 32'(busy[2]), 0);
      end else if (k > 4 && pulse[2]) begin
        n++;
      end
    end
    check("t3_quiet", n, 0);
    os_cfg = '0;

    // Hold for 10 cycles mid-count, period 9
    step(1'b0, 1'b0, 4'b1000, '0, 4'b1000, sl(3, 9));
    first = 0; n = 0;
    for (int j = 1; j <= 25; j++) begin
      hh = (j >= 5 && j <= 14);
      step(1'b0, hh, '0, '0, '0, '0);
      if (hh && pulse[3]) n++;
      if (!hh && pulse[3] && first == 0) first = j;
    end
    check("t4_hold_quiet", n, 0);
    check("t4_first", first, 20);

    // Period 0: every cycle, then stop+start
    step(1'b0, 1'b0, 4'b0001, '0, 4'b0001, sl(0, 0));
    n = 0;
    for (int k = 1; k <= 5; k++) begin
      idle();
      if (pulse[0]) n++;
    end
    check("t5_every", n, 5);
    step(1'b0, 1'b0, 4'b0001, 4'b0001, '0, '0);
    check("t5_stop_busy", 32'(busy[0]), 0);
    check("t5_stop_pulse", 32'(pulse[0]), 0);
    n = 0;
    for (int k = 1; k <= 3; k++) begin
      idle();
      if (pulse[0] || busy[0]) n++;
    end
    check("t5_stopped", n, 0);

    // Reset mid-run after loading period 7
    step(1'b0, 1'b0, 4'b0010, '0, 4'b0010, sl(1, 7));
    repeat (3) idle();
    step(1'b1, 1'b0, '0, '0, '0, '0);
    check("t6_pulse", 32'(pulse), 0);
    q.delete();
    for (int k = 1; k <= 10; k++) begin
      idle();
      if (pulse[1]) q.push_back(k);
    end
    check("t6_count", q.size(), 2);
    if (q.size() == 2) begin
      check("t6_p0", q[0], 5);
      check("t6_p1", q[1], 10);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < CH; i++) begin
        rs[i] = ($urandom_range(0, 9) == 0);
        rp[i] = ($urandom_range(0, 19) == 0);
        rl[i] = ($urandom_range(0, 9) == 0);
        rpin[i*W +: W] = W'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 15) == 0) os_cfg = CH'($urandom);
      step($urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0,
           rs, rp, rl, rpin);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
